// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int CORE_ADDR_W = 32;
  localparam int CORE_DATA_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  function automatic int streak_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Grant decision between fetch and data plus the saturating count of
// consecutive data grants taken while fetch was waiting.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_en,
  input  logic i_req_valid,
  input  logic d_req_valid,
  output logic grant_data
);

  localparam int CW = streak_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] streak_r;
  logic [CW-1:0] streak_nxt_s;
  logic          starved_s;

  assign starved_s  = i_req_valid && (streak_r == LIMIT);
  assign grant_data = d_req_valid && !starved_s;

  // Next streak value, only moves on a grant
  always_comb begin
    streak_nxt_s = streak_r;
    if (!grant_en) begin
      streak_nxt_s = streak_r;
    end else if (grant_data && i_req_valid) begin
      if (streak_r != LIMIT) begin
        streak_nxt_s = streak_r + CW'(1);
      end else begin
        streak_nxt_s = streak_r;
      end
    end else begin
      streak_nxt_s = '0;
    end
  end

  // Streak register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_r <= '0;
    end else begin
      streak_r <= streak_nxt_s;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// outstanding request at a time, routing read data back to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = CORE_ADDR_W,
  parameter int DATA_W       = CORE_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       owner_r;
  logic       kill_r;
  logic       kill_nxt_s;
  logic       grant_s;
  logic       grant_data_s;
  logic       accept_s;
  logic       resp_fire_s;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_en    (grant_s),
    .i_req_valid (i_req_valid),
    .d_req_valid (d_req_valid),
    .grant_data  (grant_data_s)
  );

  assign grant_s       = (state_r == ST_IDLE) && (i_req_valid || d_req_valid);
  assign d_req_ready   = grant_s && grant_data_s;
  assign i_req_ready   = grant_s && !grant_data_s;
  assign mem_req_valid = (state_r == ST_ISSUE);
  assign accept_s      = mem_req_valid && mem_req_ready;
  assign resp_fire_s   = (state_r == ST_WAIT) && mem_resp_valid;

  // A killed fetch still consumes its response; only the valid is dropped
  assign d_resp_valid = resp_fire_s && (owner_r == OWN_DATA);
  assign i_resp_valid = resp_fire_s && (owner_r == OWN_FETCH) && !kill_r && !i_kill;
  assign i_resp_data  = mem_resp_data;
  assign d_resp_data  = mem_resp_data;

  // Next state and kill flag
  always_comb begin
    state_nxt_s = state_r;
    kill_nxt_s  = kill_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!accept_s) begin
          state_nxt_s = ST_ISSUE;
        end else if (mem_we != '0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (state_nxt_s == ST_IDLE) begin
      kill_nxt_s = 1'b0;
    end else if ((state_r != ST_IDLE) && (owner_r == OWN_FETCH) && i_kill) begin
      kill_nxt_s = 1'b1;
    end else begin
      kill_nxt_s = kill_r;
    end
  end

  // FSM state and kill flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      kill_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      kill_r  <= kill_nxt_s;
    end
  end

  // Request fields and owner captured at grant, held through ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      owner_r   <= OWN_FETCH;
    end else if (grant_s) begin
      if (grant_data_s) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
        owner_r   <= OWN_DATA;
      end else begin
        mem_addr  <= i_addr;
        mem_we    <= '0;
        mem_wdata <= '0;
        owner_r   <= OWN_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level
// reference model of the arbiter and a simple byte-maskable memory.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid, i_req_ready, i_kill, i_resp_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_we;
  logic [DW-1:0] d_wdata, d_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_wdata, mem_resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_kill(i_kill), .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; i_addr = '0; i_kill = 1'b0;
    d_req_valid = 1'b0; d_addr = '0; d_we = 4'h0; d_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic finish_read();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = $urandom;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    settle();
    n_checks++;
    if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00000",
        {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid});
    end
    n_checks++;
    if ({mem_addr, mem_we, mem_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h/%h/%h expected 0", mem_addr, mem_we, mem_wdata);
    end
    tick();
    rst_n = 1'b1;
    settle();
    n_checks++;
    if ({i_req_ready, d_req_ready, mem_req_valid} !== 3'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected 000",
        {i_req_ready, d_req_ready, mem_req_valid});
    end
    tick();
  endtask

  task automatic test_single_fetch();
    i_req_valid = 1'b1; i_addr = 32'h0000_0100;
    settle();
    n_checks++;
    if ({i_req_ready, d_req_ready, mem_req_valid} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_c1: got %b expected 100", {i_req_ready, d_req_ready, mem_req_valid});
    end
    tick();
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    n_checks++;
    if ({mem_req_valid, mem_addr, mem_we, i_req_ready} !== {1'b1, 32'h0000_0100, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL fetch_c2: got v=%b a=%h we=%h expected v=1 a=00000100 we=0",
        mem_req_valid, mem_addr, mem_we);
    end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    settle();
    n_checks++;
    if ({i_resp_valid, d_resp_valid, i_resp_data, mem_req_valid} !== {2'b10, 32'h0000_0013, 1'b0}) begin
      n_fail++; $display("FAIL fetch_c3: got iv=%b dv=%b data=%h expected iv=1 dv=0 data=00000013",
        i_resp_valid, d_resp_valid, i_resp_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_priority();
    i_req_valid = 1'b1; i_addr = 32'h0000_0400;
    d_req_valid = 1'b1; d_addr = 32'h0000_2000; d_we = 4'h0;
    settle();
    n_checks++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL prio_grant: got d=%b i=%b expected d=1 i=0", d_req_ready, i_req_ready);
    end
    tick();
    d_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    n_checks++;
    if ({mem_addr, i_req_ready} !== {32'h0000_2000, 1'b0}) begin
      n_fail++; $display("FAIL prio_issue: got a=%h ir=%b expected a=00002000 ir=0", mem_addr, i_req_ready);
    end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    settle();
    n_checks++;
    if ({d_resp_valid, i_resp_valid, d_resp_data, i_req_ready} !== {2'b10, 32'hCAFE_F00D, 1'b0}) begin
      n_fail++; $display("FAIL prio_resp: got dv=%b iv=%b data=%h ir=%b expected dv=1 iv=0 data=cafef00d ir=0",
        d_resp_valid, i_resp_valid, d_resp_data, i_req_ready);
    end
    tick();
    mem_resp_valid = 1'b0;
    settle();
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL prio_fetch_next: got i=%b d=%b expected i=1 d=0", i_req_ready, d_req_ready);
    end
    tick();
    i_req_valid = 1'b0;
    finish_read();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_d;
    for (int k = 0; k < 11; k++) begin
      i_req_valid = 1'b1; i_addr = 32'h0000_0500;
      d_req_valid = 1'b1; d_addr = 32'h0000_4000 + 32'(k * 4); d_we = 4'h0;
      settle();
      exp_d = ((k % (LIMIT + 1)) != LIMIT);
      n_checks++;
      if ({d_req_ready, i_req_ready} !== {exp_d, ~exp_d}) begin
        n_fail++; $display("FAIL starve_grant_%0d: got d=%b i=%b expected d=%b i=%b",
          k, d_req_ready, i_req_ready, exp_d, ~exp_d);
      end
      tick();
      finish_read();
    end
    idle_inputs();
  endtask

  task automatic test_write_stall();
    d_req_valid = 1'b1; d_we = 4'hF; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h0000_3000;
    settle();
    n_checks++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL wr_grant: got d=%b i=%b expected d=1 i=0", d_req_ready, i_req_ready);
    end
    tick();
    d_req_valid = 1'b0; d_addr = 32'hFFFF_FFFC; d_wdata = 32'h0; d_we = 4'h0; mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_req_ready = 1'b1;
      settle();
      n_checks++;
      if ({mem_req_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h0000_3000, 4'hF, 32'hDEAD_BEEF}) begin
        n_fail++; $display("FAIL wr_stable_%0d: got v=%b a=%h we=%h wd=%h expected v=1 a=00003000 we=f wd=deadbeef",
          k, mem_req_valid, mem_addr, mem_we, mem_wdata);
      end
      tick();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
    d_req_valid = 1'b1; d_addr = 32'h0000_3000;
    settle();
    n_checks++;
    if ({d_req_ready, d_resp_valid, i_resp_valid, mem_req_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL wr_back_idle: got dr=%b dv=%b iv=%b mv=%b expected dr=1 dv=0 iv=0 mv=0",
        d_req_ready, d_resp_valid, i_resp_valid, mem_req_valid);
    end
    tick();
    mem_resp_valid = 1'b0; d_req_valid = 1'b0;
    finish_read();
    idle_inputs();
  endtask

  task automatic test_kill();
    i_req_valid = 1'b1; i_addr = 32'h0000_0200;
    settle();
    n_checks++;
    if (i_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_grant: got %b expected 1", i_req_ready);
    end
    tick();
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; i_kill = 1'b1;
    settle();
    n_checks++;
    if ({i_resp_valid, mem_req_valid, i_req_ready} !== 3'b000) begin
      n_fail++; $display("FAIL kill_wait: got iv=%b mv=%b ir=%b expected 000", i_resp_valid, mem_req_valid, i_req_ready);
    end
    tick();
    i_kill = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0093;
    settle();
    n_checks++;
    if ({i_resp_valid, d_resp_valid, i_resp_data} !== {2'b00, 32'h0000_0093}) begin
      n_fail++; $display("FAIL kill_suppress: got iv=%b dv=%b data=%h expected iv=0 dv=0 data=00000093",
        i_resp_valid, d_resp_valid, i_resp_data);
    end
    tick();
    mem_resp_valid = 1'b0; i_req_valid = 1'b1; i_addr = 32'h0000_0204;
    settle();
    n_checks++;
    if (i_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_idle_again: got %b expected 1", i_req_ready);
    end
    tick();
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0113;
    settle();
    n_checks++;
    if ({i_resp_valid, i_resp_data} !== {1'b1, 32'h0000_0113}) begin
      n_fail++; $display("FAIL kill_next_fetch: got iv=%b data=%h expected iv=1 data=00000113",
        i_resp_valid, i_resp_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    i_req_valid = 1'b1; i_addr = 32'h0000_0300;
    tick();
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid, mem_addr} !== {5'b0, 32'h0}) begin
      n_fail++; $display("FAIL rstmid_async: got ctl=%b a=%h expected ctl=00000 a=0",
        {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid}, mem_addr);
    end
    tick();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
    settle();
    n_checks++;
    if ({i_resp_valid, d_resp_valid, i_req_ready, d_req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata}
        !== {5'b0, 68'h0}) begin
      n_fail++; $display("FAIL rstmid_late_resp: got iv=%b dv=%b mv=%b a=%h expected all 0",
        i_resp_valid, d_resp_valid, mem_req_valid, mem_addr);
    end
    tick();
    mem_resp_valid = 1'b0; d_req_valid = 1'b1; d_addr = 32'h0000_0040;
    settle();
    n_checks++;
    if (d_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_idle: got %b expected 1", d_req_ready);
    end
    tick();
    d_req_valid = 1'b0;
    finish_read();
    idle_inputs();
  endtask

  task automatic test_random(input int n_cycles);
    logic [31:0] phys_mem [16];
    logic [31:0] ref_mem [16];
    int   phase, wait_cnt, streak;
    logic own_d, killed, resp_now, exp_d, any_req, exp_iv;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic [3:0]  exp_we;
    phase = 0; wait_cnt = 0; streak = 0; own_d = 1'b0; killed = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_data = '0; exp_we = 4'h0;
    for (int k = 0; k < 16; k++) begin
      phys_mem[k] = $urandom;
      ref_mem[k] = phys_mem[k];
    end
    for (int c = 0; c < n_cycles; c++) begin
      i_req_valid = ($urandom_range(0, 2) != 0);
      d_req_valid = ($urandom_range(0, 1) == 1);
      i_addr  = 32'h0000_1000 | ($urandom & 32'h0000_003C);
      d_addr  = 32'h0000_1000 | ($urandom & 32'h0000_003C);
      d_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      d_wdata = $urandom;
      i_kill  = ($urandom_range(0, 9) == 0);
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      resp_now       = (phase == 2) && (wait_cnt == 0);
      mem_resp_valid = resp_now || ((phase != 2) && ($urandom_range(0, 7) == 0));
      mem_resp_data  = resp_now ? phys_mem[mem_addr[5:2]] : $urandom;
      any_req = i_req_valid || d_req_valid;
      exp_d   = d_req_valid && !(i_req_valid && (streak == LIMIT));
      settle();
      n_checks++;
      if ({i_resp_data, d_resp_data} !== {mem_resp_data, mem_resp_data}) begin
        n_fail++; $display("FAIL rnd_data_pass c=%0d: got %h/%h expected %h", c, i_resp_data, d_resp_data, mem_resp_data);
      end
      case (phase)
        0: begin
          n_checks++;
          if ({i_req_ready, d_req_ready, mem_req_valid, i_resp_valid, d_resp_valid}
              !== {any_req && !exp_d, exp_d, 3'b000}) begin
            n_fail++; $display("FAIL rnd_idle c=%0d: got ir=%b dr=%b mv=%b iv=%b dv=%b expected ir=%b dr=%b",
              c, i_req_ready, d_req_ready, mem_req_valid, i_resp_valid, d_resp_valid, any_req && !exp_d, exp_d);
          end
        end
        1: begin
          n_checks++;
          if ({i_req_ready, d_req_ready, mem_req_valid, i_resp_valid, d_resp_valid, mem_addr, mem_we}
              !== {5'b00100, exp_addr, exp_we}) begin
            n_fail++; $display("FAIL rnd_issue c=%0d: got mv=%b a=%h we=%h expected mv=1 a=%h we=%h",
              c, mem_req_valid, mem_addr, mem_we, exp_addr, exp_we);
          end
          if (exp_we != 4'h0) begin
            n_checks++;
            if (mem_wdata !== exp_wdata) begin
              n_fail++; $display("FAIL rnd_wdata c=%0d: got %h expected %h", c, mem_wdata, exp_wdata);
            end
          end
        end
        default: begin
          exp_iv = resp_now && !own_d && !killed && !i_kill;
          n_checks++;
          if ({i_req_ready, d_req_ready, mem_req_valid, i_resp_valid, d_resp_valid}
              !== {3'b000, exp_iv, resp_now && own_d}) begin
            n_fail++; $display("FAIL rnd_wait c=%0d: got iv=%b dv=%b mv=%b expected iv=%b dv=%b",
              c, i_resp_valid, d_resp_valid, mem_req_valid, exp_iv, resp_now && own_d);
          end
          if (resp_now) begin
            n_checks++;
            if (mem_resp_data !== exp_data) begin
              n_fail++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, mem_resp_data, exp_data);
            end
          end
        end
      endcase
      case (phase)
        0: begin
          if (any_req) begin
            own_d = exp_d;
            killed = 1'b0;
            if (exp_d) begin
              exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata;
              streak = i_req_valid ? ((streak < LIMIT) ? streak + 1 : streak) : 0;
            end else begin
              exp_addr = i_addr; exp_we = 4'h0; exp_wdata = '0;
              streak = 0;
            end
            exp_data = ref_mem[exp_addr[5:2]];
            if (exp_we != 4'h0) ref_mem[exp_addr[5:2]] = merge(ref_mem[exp_addr[5:2]], exp_wdata, exp_we);
            phase = 1;
          end
        end
        1: begin
          if (!own_d && i_kill) killed = 1'b1;
          if (mem_req_ready) begin
            if (exp_we != 4'h0) begin
              phys_mem[mem_addr[5:2]] = merge(phys_mem[mem_addr[5:2]], mem_wdata, mem_we);
              phase = 0;
            end else begin
              phase = 2;
              wait_cnt = $urandom_range(0, 3);
            end
          end
        end
        default: begin
          if (resp_now) begin
            phase = 0;
          end else begin
            if (!own_d && i_kill) killed = 1'b1;
            wait_cnt--;
          end
        end
      endcase
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_write_stall();
    test_kill();
    test_reset_mid();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
